// File: rtl/dcr_bank.sv
// dcr_bank: device control register bank for kernel launch metadata.
// Holds NUM_REGS config registers (reg 0 = thread count), a CTRL/STATUS
// pair, a single-outstanding request/response host port and a small
// IDLE -> LAUNCH -> RUN launch state machine that strobes the dispatcher.
module dcr_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
  output logic [DATA_WIDTH-1:0]          thread_count,
  output logic                           kernel_start,
  output logic                           kernel_abort,
  input  logic                           kernel_done,
  output logic                           busy
);

  // CTRL and STATUS sit directly above the config registers.
  localparam logic [ADDR_WIDTH:0]   NREG_A    = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(NUM_REGS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cfg_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] cfg_d [NUM_REGS];
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  abort_q, abort_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  accept;
  logic                  in_flight;
  logic                  is_cfg, is_ctrl, is_stat;
  logic                  req_err;
  logic                  ctrl_ok;
  logic                  do_start, do_abort, run_done;
  logic                  cfg_wr_ok;
  logic [DATA_WIDTH-1:0] cfg_rd;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_data;

  // Host handshake: one response outstanding; a consumed response frees the slot
  // in the same cycle so back-to-back requests stream at one per clock.
  always_comb begin
    req_ready = !rst && (!rsp_valid_q || rsp_ready);
    accept    = req_valid && req_ready;
  end

  // Address decode, error classification and the side effects of an accepted request.
  always_comb begin
    in_flight = (state_q != S_IDLE);
    is_cfg    = ({1'b0, req_addr} < NREG_A);
    is_ctrl   = (req_addr == CTRL_ADDR);
    is_stat   = (req_addr == STAT_ADDR);
    req_err   = (!is_cfg && !is_ctrl && !is_stat)
             || (req_write && is_stat)
             || (req_write && is_cfg && in_flight)
             || (req_write && is_ctrl && req_wdata[0] && in_flight);
    ctrl_ok   = accept && req_write && is_ctrl && !req_err;
    cfg_wr_ok = accept && req_write && is_cfg && !req_err;
    run_done  = (state_q == S_RUN) && kernel_done;
    do_start  = ctrl_ok && req_wdata[0] && (state_q == S_IDLE);
    // Completion beats a simultaneous abort: the kernel already finished.
    do_abort  = ctrl_ok && req_wdata[2] && (state_q == S_RUN) && !kernel_done;
  end

  // Read mux: config register, STATUS snapshot, or zero for CTRL.
  always_comb begin
    cfg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_WIDTH'(i)) cfg_rd = cfg_q[i];
    end
    status_word = {{(DATA_WIDTH-3){1'b0}}, aborted_q, done_q, in_flight};
    rd_data     = '0;
    if (is_cfg)       rd_data = cfg_rd;
    else if (is_stat) rd_data = status_word;
  end

  // Config register next state: writes land on the accept edge when allowed.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_d[i] = cfg_q[i];
      if (cfg_wr_ok && (req_addr == ADDR_WIDTH'(i))) cfg_d[i] = req_wdata;
    end
  end

  // Sticky status flags: clears are applied first so a same-cycle event still sets.
  always_comb begin
    done_d    = done_q;
    aborted_d = aborted_q;
    if ((ctrl_ok && req_wdata[1]) || do_start) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end
    if (run_done) done_d    = 1'b1;
    if (do_abort) aborted_d = 1'b1;
    abort_d = do_abort;
  end

  // Response slot: load on accept, drop on consume, otherwise hold stable.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_rdata_d = (!req_write && !req_err) ? rd_data : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Launch FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (do_start) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN:    if (run_done || do_abort) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Launch FSM outputs: start strobe is the single LAUNCH cycle.
  always_comb begin
    kernel_start = (state_q == S_LAUNCH);
    busy         = in_flight;
  end

  // Launch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Config, status and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      abort_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= cfg_d[i];
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      abort_q     <= abort_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Direct register outputs toward host and dispatcher.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] = cfg_q[i];
    thread_count = cfg_q[0];
    kernel_abort = abort_q;
    rsp_valid    = rsp_valid_q;
    rsp_err      = rsp_err_q;
    rsp_rdata    = rsp_rdata_q;
  end

endmodule

// File: tb/tb_dcr_bank.sv
// tb_dcr_bank: scoreboard bench for dcr_bank with a behavioural model of the
// register map, launch bookkeeping and response slot.
module tb_dcr_bank;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int AW = 3;

  logic            clk, rst;
  logic            req_valid, req_ready, req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [NR*DW-1:0] cfg_regs;
  logic [DW-1:0]   thread_count;
  logic            kernel_start, kernel_abort, kernel_done, busy;

  dcr_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfg_regs(cfg_regs), .thread_count(thread_count),
    .kernel_start(kernel_start), .kernel_abort(kernel_abort),
    .kernel_done(kernel_done), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: register contents, whether a kernel is outstanding and the edge at
  // which its launch was accepted, sticky flags and the response slot.
  logic [DW-1:0] m_regs [NR];
  bit            m_inflight, m_done, m_aborted, m_abort_pulse, m_rsp_pend;
  int            m_edge, m_start_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_inflight = 0; m_done = 0; m_aborted = 0; m_abort_pulse = 0; m_rsp_pend = 0;
    m_start_edge = -10;
    sb_q.delete();
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge(input bit v, input bit w, input int a, input logic [DW-1:0] d,
                            input bit rr, input bit kd);
    bit   ready, acc, running, err, abort_now;
    rsp_t r;
    m_edge++;
    ready     = !m_rsp_pend || rr;
    acc       = v && ready;
    running   = m_inflight && (m_edge >= m_start_edge + 2);
    abort_now = 0;
    if (acc) begin
      err = 0;
      if (a > NR + 1) err = 1;
      if (w && a == NR + 1) err = 1;
      if (w && a < NR && m_inflight) err = 1;
      if (w && a == NR && d[0] && m_inflight) err = 1;
      r.err   = err;
      r.rdata = 0;
      if (!w && !err) begin
        if (a < NR)          r.rdata = m_regs[a];
        else if (a == NR + 1) r.rdata = DW'({m_aborted, m_done, m_inflight});
      end
      sb_q.push_back(r);
      if (w && !err && a < NR) m_regs[a] = d;
      if (w && !err && a == NR) begin
        if (d[1]) begin m_done = 0; m_aborted = 0; end
        if (d[0] && !m_inflight) begin
          m_inflight = 1; m_start_edge = m_edge; m_done = 0; m_aborted = 0;
        end
        if (d[2] && running && !kd) abort_now = 1;
      end
    end
    if (running && kd) begin m_done = 1; m_inflight = 0; end
    if (abort_now) begin m_inflight = 0; m_aborted = 1; end
    m_abort_pulse = abort_now;
    m_rsp_pend    = acc ? 1'b1 : (rr ? 1'b0 : m_rsp_pend);
  endtask

  // One cycle of stimulus; outputs from the previous edge are checked mid-cycle.
  task automatic step(input bit v, input bit w, input int a, input logic [DW-1:0] d,
                      input bit rr, input bit kd);
    logic [NR*DW-1:0] exp_cfg;
    req_valid = v; req_write = w; req_addr = AW'(a); req_wdata = d;
    rsp_ready = rr; kernel_done = kd;
    @(negedge clk);
    for (int i = 0; i < NR; i++) exp_cfg[i*DW +: DW] = m_regs[i];
    chk("req_ready", req_ready, !m_rsp_pend || rr);
    chk("rsp_valid", rsp_valid, m_rsp_pend);
    chk("kernel_start", kernel_start, m_inflight && (m_edge == m_start_edge));
    chk("kernel_abort", kernel_abort, m_abort_pulse);
    chk("busy", busy, m_inflight);
    chk("thread_count", thread_count, m_regs[0]);
    chk("cfg_regs", cfg_regs, exp_cfg);
    @(posedge clk);
    model_edge(v, w, a, d, rr, kd);
    #1;
  endtask

  task automatic xfer(input bit w, input int a, input logic [DW-1:0] d);
    step(1, w, a, d, 1, 0);
  endtask

  task automatic idle(input int n, input bit kd);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 1, kd);
  endtask

  // Monitor: every cycle the response is presented it must match the queue head;
  // the entry retires on the handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        chk("rsp_rdata", rsp_rdata, sb_q[0].rdata);
        chk("rsp_err", rsp_err, sb_q[0].err);
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1; kernel_done = 0;
    m_edge = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cfg", cfg_regs, 0);
    rst = 1'b0;

    // Config write/read.
    xfer(1, 0, 8'h20);
    xfer(1, 2, 8'h40);
    xfer(0, 0, 8'h00);
    xfer(0, 2, 8'h00);
    idle(1, 0);
    chk("tc_0x20", thread_count, 8'h20);
    chk("cfg2_0x40", cfg_regs[23:16], 8'h40);

    // Launch, rejected write while busy, completion.
    xfer(1, NR, 8'h01);
    chk("start_strobe", kernel_start, 1);
    xfer(1, 0, 8'h05);
    chk("busy_run", busy, 1);
    idle(1, 0);
    chk("tc_held", thread_count, 8'h20);
    xfer(1, NR, 8'h01);
    idle(1, 1);
    chk("busy_after_done", busy, 0);
    xfer(0, NR + 1, 8'h00);
    xfer(0, NR, 8'h00);

    // Abort in RUN, then clear.
    xfer(1, NR, 8'h01);
    idle(2, 0);
    xfer(1, NR, 8'h04);
    chk("abort_strobe", kernel_abort, 1);
    xfer(0, NR + 1, 8'h00);
    xfer(1, NR, 8'h02);
    xfer(0, NR + 1, 8'h00);

    // Abort in IDLE ignored; abort and done together: done wins.
    xfer(1, NR, 8'h04);
    xfer(1, NR, 8'h01);
    idle(2, 0);
    step(1, 1, NR, 8'h04, 1, 1);
    xfer(0, NR + 1, 8'h00);

    // Backpressure then back-to-back reads.
    xfer(1, 1, 8'hA5);
    xfer(0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 3, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) xfer(0, i, 8'h00);
    idle(1, 0);

    // Errors and stray completion.
    xfer(0, NR + 2, 8'h00);
    xfer(1, NR + 1, 8'hFF);
    xfer(1, 7, 8'h11);
    idle(1, 1);
    xfer(0, NR + 1, 8'h00);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      int            a;
      logic [DW-1:0] d;
      a = int'($urandom_range(0, 7));
      d = (a == NR) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end
    idle(2, 0);

    // Reset mid-RUN with a response pending.
    xfer(1, NR, 8'h02);
    xfer(1, NR, 8'h01);
    idle(2, 0);
    xfer(0, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_rdata", rsp_rdata, 0);
    chk("arst_rsp_err", rsp_err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_kstart", kernel_start, 0);
    chk("arst_kabort", kernel_abort, 0);
    chk("arst_cfg", cfg_regs, 0);
    chk("arst_tc", thread_count, 0);
    chk("arst_req_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3, 0);
    xfer(0, NR + 1, 8'h00);
    idle(2, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
